// File: rtl/alu_exec_pkg.sv
// ----------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the ALU execute stage:
//   - opcode encodings (NOP .. SRA, plus MFHI/MFLO)
//   - sequencer state encoding
//   - bit positions inside the {z,c,o,s} flag register
//   - small opcode classification helpers
// The optional HI/LO read ops are enabled by the macro ALU_EXEC_HILO_READ_EN.
// The encodings below are defined either way.
// ----------------------------------------------------------------------------
package alu_exec_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_COMP  = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MFHI  = 4'd11;
    localparam logic [3:0] OP_MFLO  = 4'd12;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Opcodes that go through the external ALU and need the settle window.
    function automatic logic is_alu_op(input logic [3:0] code);
        return (code >= OP_ADD) && (code <= OP_SRA);
    endfunction

    // Opcodes whose result lands in HI/LO instead of the register file.
    function automatic logic is_mult_op(input logic [3:0] code);
        return (code == OP_MULT) || (code == OP_MULTU);
    endfunction

endpackage

// File: rtl/alu_exec_hilo.sv
// ----------------------------------------------------------------------------
// alu_exec_hilo
// Architectural HI/LO register pair, written together from the ALU product.
// Ports:
//   clk, rstn      clock / synchronous active-low reset
//   wen            load hi_d/lo_d on this edge
//   hi_d, lo_d     new HI/LO values
//   hi, lo         current committed HI/LO
// ----------------------------------------------------------------------------
module alu_exec_hilo (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wen,
    input  logic [31:0] hi_d,
    input  logic [31:0] lo_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of the order of statements.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hi <= '0;
            lo <= '0;
        end else if (wen) begin
            hi <= hi_d;
            lo <= lo_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ----------------------------------------------------------------------------
// alu_exec_stage
// Execute-stage sequencer around a combinational ALU. Accepts one op from
// decode, holds the ALU inputs for SETTLE_CYCLES cycles, captures result,
// HI/LO and flags, then offers the result to writeback (valid/ready).
// Optional feature macro: ALU_EXEC_HILO_READ_EN (codes 11/12 = MFHI/MFLO,
// served in-stage from the committed HI/LO). Without it, 11..15 are illegal.
// Ports:
//   clk, rstn                  clock / synchronous active-low reset
//   in_valid/in_ready          decode handshake; in_code/in_a/in_b/in_rd op
//   alu_inp1/alu_inp2/alu_code operands and opcode driven to the ALU
//   alu_outp, alu_mult_*       ALU result and product halves
//   alu_*flag                  ALU flags
//   out_valid/out_ready        writeback handshake
//   out_data/out_rd/out_wen    result, destination, register-file write
//   hi, lo, flags              architectural HI/LO and {z,c,o,s}
//   err                        one-cycle pulse when an illegal op is accepted
// ----------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int RD_W          = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_code,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [RD_W-1:0] in_rd,
    output logic [31:0]     alu_inp1,
    output logic [31:0]     alu_inp2,
    output logic [3:0]      alu_code,
    input  logic [31:0]     alu_outp,
    input  logic [31:0]     alu_mult_high,
    input  logic [31:0]     alu_mult_low,
    input  logic            alu_zflag,
    input  logic            alu_carryflag,
    input  logic            alu_ovfflag,
    input  logic            alu_signflag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic [3:0]      flags,
    output logic            err
);

    function automatic logic is_illegal(input logic [3:0] code);
`ifdef ALU_EXEC_HILO_READ_EN
        return code > OP_MFLO;
`else
        return code > OP_SRA;
`endif
    endfunction

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      code_q;
    logic [RD_W-1:0] rd_q;
    logic            accept, capture, transfer;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign capture  = (state == ST_SETTLE) && (cnt == 4'd0);
    assign transfer = (state == ST_DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_code  = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = is_alu_op(in_code) ? ST_SETTLE : ST_DONE;
            end
            ST_SETTLE: begin
                alu_code = code_q;
                if (cnt == 4'd0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                alu_code  = code_q;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= '0;
            code_q   <= '0;
            rd_q     <= '0;
            alu_inp1 <= '0;
            alu_inp2 <= '0;
            out_data <= '0;
            out_rd   <= '0;
            out_wen  <= 1'b0;
            flags    <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                code_q   <= in_code;
                rd_q     <= in_rd;
                alu_inp1 <= in_a;
                alu_inp2 <= in_b;
                cnt      <= 4'(SETTLE_CYCLES - 1);
                // Ops that bypass the ALU complete right here.
                if (!is_alu_op(in_code)) begin
                    out_rd   <= in_rd;
                    out_data <= '0;
                    out_wen  <= 1'b0;
                    err      <= is_illegal(in_code);
`ifdef ALU_EXEC_HILO_READ_EN
                    // Reads the HI/LO committed before this op.
                    if (in_code == OP_MFHI || in_code == OP_MFLO) begin
                        out_data <= (in_code == OP_MFHI) ? hi : lo;
                        out_wen  <= (in_rd != '0);
                    end
`endif
                end
            end else if (state == ST_SETTLE) begin
                if (capture) begin
                    out_rd <= rd_q;
                    if (is_mult_op(code_q)) begin
                        out_data <= '0;
                        out_wen  <= 1'b0;
                    end else begin
                        out_data <= alu_outp;
                        out_wen  <= (rd_q != '0);
                        flags[FLAG_Z] <= alu_zflag;
                        flags[FLAG_C] <= alu_carryflag;
                        flags[FLAG_O] <= alu_ovfflag;
                        flags[FLAG_S] <= alu_signflag;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (transfer) begin
                out_wen <= 1'b0;
            end
        end
    end

    alu_exec_hilo u_hilo (
        .clk  (clk),
        .rstn (rstn),
        .wen  (capture && is_mult_op(code_q)),
        .hi_d (alu_mult_high),
        .lo_d (alu_mult_low),
        .hi   (hi),
        .lo   (lo)
    );

endmodule

// File: tb/tb_alu_exec_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_stage
// Bench for alu_exec_stage with SETTLE_CYCLES=2. The bench plays the
// combinational ALU, keeps an architectural model of out_data/out_rd/out_wen,
// HI/LO and flags per op, and compares every cycle out_valid is high.
// ----------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int SETTLE = 2;
    localparam int RD_W   = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_code;
    logic [31:0]     in_a, in_b;
    logic [RD_W-1:0] in_rd;
    logic [31:0]     alu_inp1, alu_inp2;
    logic [3:0]      alu_code;
    logic [31:0]     alu_outp, alu_mult_high, alu_mult_low;
    logic [3:0]      alu_f;
    logic            out_valid, out_ready;
    logic [31:0]     out_data;
    logic [RD_W-1:0] out_rd;
    logic            out_wen;
    logic [31:0]     hi, lo;
    logic [3:0]      flags;
    logic            err;

    always #5 clk = ~clk;

    alu_exec_stage #(.SETTLE_CYCLES(SETTLE), .RD_W(RD_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_rd         (in_rd),
        .alu_inp1      (alu_inp1),
        .alu_inp2      (alu_inp2),
        .alu_code      (alu_code),
        .alu_outp      (alu_outp),
        .alu_mult_high (alu_mult_high),
        .alu_mult_low  (alu_mult_low),
        .alu_zflag     (alu_f[3]),
        .alu_carryflag (alu_f[2]),
        .alu_ovfflag   (alu_f[1]),
        .alu_signflag  (alu_f[0]),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .hi            (hi),
        .lo            (lo),
        .flags         (flags),
        .err           (err)
    );

    // Behavioural ALU: result, product halves and {z,c,o,s}.
    function automatic void alu_eval(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [31:0] mh,
                                     output logic [31:0] ml, output logic [3:0] f);
        logic [32:0] w;
        logic [63:0] p;
        logic        cy, ov;
        r = '0; mh = '0; ml = '0; cy = 1'b0; ov = 1'b0; p = '0; w = '0;
        case (c)
            4'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32];
                        ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd2: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cy = w[32];
                        ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                        mh = p[63:32]; ml = p[31:0]; end
            4'd4: begin p = {32'd0, a} * {32'd0, b}; mh = p[63:32]; ml = p[31:0]; end
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a & b;
            4'd7: r = a ^ b;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        f = {(r == 32'd0), cy, ov, r[31]};
    endfunction

    always_comb alu_eval(alu_code, alu_inp1, alu_inp2, alu_outp, alu_mult_high, alu_mult_low, alu_f);

    typedef struct {
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
        logic            wen;
        logic [31:0]     hi;
        logic [31:0]     lo;
        logic [3:0]      flags;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl_hi = '0, mdl_lo = '0;
    logic [3:0]  mdl_flags = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: whenever a result is offered, it must match the model.
    always @(negedge clk) begin
        if (rstn === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: out_valid=1 with no op outstanding (t=%0t)", $time);
            end else begin
                check("out_data", out_data, exp_q[0].data);
                check("out_rd",   out_rd,   exp_q[0].rd);
                check("out_wen",  out_wen,  exp_q[0].wen);
                check("hi",       hi,       exp_q[0].hi);
                check("lo",       lo,       exp_q[0].lo);
                check("flags",    flags,    exp_q[0].flags);
                check("in_ready_while_done", in_ready, 1'b0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Offer one op, record its architectural outcome, return once out_valid.
    task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd);
        int          n;
        exp_t        e;
        logic [31:0] r, mh, ml;
        logic [3:0]  f;
        logic        direct;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: in_ready=0 after 50 cycles, required 1");
            return;
        end
        in_valid = 1'b1; in_code = code; in_a = a; in_b = b; in_rd = rd;
        alu_eval(code, a, b, r, mh, ml, f);
        direct = !((code >= 4'd1) && (code <= 4'd10));
        e.rd = rd; e.wen = 1'b0; e.data = '0;
        if (code == 4'd3 || code == 4'd4) begin
            mdl_hi = mh; mdl_lo = ml;
        end else if (!direct) begin
            e.data = r; e.wen = (rd != '0); mdl_flags = f;
        end
        e.hi = mdl_hi; e.lo = mdl_lo; e.flags = mdl_flags;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("err_on_accept", err, (code >= 4'd11));
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("valid_latency", n, direct ? 0 : SETTLE);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_code = '0; in_a = '0; in_b = '0; in_rd = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_wen", out_wen, 1'b0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", flags, 4'd0);
        check("rst_err", err, 1'b0);
        check("rst_alu_code", alu_code, 4'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        do_op(4'd1, 32'd5, 32'd7, 5'd3);
        check("add_data", out_data, 32'd12);
        check("add_rd", out_rd, 5'd3);
        check("add_wen", out_wen, 1'b1);
        check("add_flags", flags, 4'b0000);
        check("alu_code_held", alu_code, 4'd1);

        do_op(4'd2, 32'd5, 32'd5, 5'd0);
        check("sub_data", out_data, 32'd0);
        check("sub_wen_rd0", out_wen, 1'b0);
        check("sub_flags", flags, 4'b1100);

        do_op(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd4);
        check("ovf_data", out_data, 32'h8000_0000);
        check("ovf_flags", flags, 4'b0011);

        do_op(4'd3, 32'hFFFF_FFFD, 32'd4, 5'd9);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF4);
        check("mult_wen", out_wen, 1'b0);
        check("mult_flags", flags, 4'b0011);

        do_op(4'd4, 32'hFFFF_FFFF, 32'd2, 5'd1);
        check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        do_op(4'd10, 32'h8000_0000, 32'd4, 5'd2);
        check("sra_data", out_data, 32'hF800_0000);
        do_op(4'd9, 32'h8000_0000, 32'd4, 5'd2);
        check("srl_data", out_data, 32'h0800_0000);
        do_op(4'd8, 32'h0000_0003, 32'd31, 5'd2);
        check("sll_data", out_data, 32'h8000_0000);
        do_op(4'd7, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd8);
        check("xor_data", out_data, 32'h5A5A_A5A5);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd10);
        check("comp_data", out_data, 32'd1);

        do_op(4'd0, 32'd1, 32'd2, 5'd6);
        check("nop_wen", out_wen, 1'b0);
        check("nop_rd", out_rd, 5'd6);

        do_op(4'd13, 32'd1, 32'd2, 5'd7);
        check("ill_wen", out_wen, 1'b0);
        @(posedge clk); #1;
        check("err_pulse_width", err, 1'b0);

        // Backpressure: hold DONE for 5 cycles while decode offers another op.
        out_ready = 1'b0;
        do_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5);
        in_valid = 1'b1; in_code = 4'd1; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", out_valid, 1'b0);
        check("bp_released_in_ready", in_ready, 1'b1);
        check("bp_wen_dropped", out_wen, 1'b0);
        check("bp_data_held", out_data, 32'hF000_F000);
        check("bp_rd_held", out_rd, 5'd5);

        // Reset during SETTLE discards the op and clears all state.
        in_valid = 1'b1; in_code = 4'd1; in_a = 32'd1; in_b = 32'd2; in_rd = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_in_ready", in_ready, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out", {out_data, 27'd0, out_rd}, 64'd0);
        check("midrst_wen_err", {out_wen, err}, 2'b00);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_flags", flags, 4'd0);
        check("midrst_alu", {alu_inp1, alu_code}, 36'd0);
        mdl_hi = '0; mdl_lo = '0; mdl_flags = '0;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_valid", out_valid, 1'b0);

        do_op(4'd1, 32'd2, 32'd3, 5'd1);
        check("post_rst_add", out_data, 32'd5);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
